// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Main control FSM of the multicycle 16-bit CPU. Sequences fetch,
//            decode, execute, memory access and writeback; drives datapath mux
//            selects, write enables and the 3-bit ALUOp for ALU_Control.
//            Stalls on the memory ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter logic [1:0] PC_INC_SEL = 2'd1,  // alu_src_b: constant +2
    parameter logic [1:0] IMM_SEL    = 2'd2,  // alu_src_b: sign-extended imm
    parameter logic [1:0] BR_OFF_SEL = 2'd3   // alu_src_b: sign-extended imm << 1
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       branch_ne,
    output logic [1:0] pc_source,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic       halted,
    output logic [3:0] state
);

    // Opcode map (IR[15:12])
    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_SHI   = 4'h1;
    localparam logic [3:0] OP_ADDI  = 4'h2;
    localparam logic [3:0] OP_SLTI  = 4'h3;
    localparam logic [3:0] OP_LW    = 4'h4;
    localparam logic [3:0] OP_SW    = 4'h5;
    localparam logic [3:0] OP_BEQ   = 4'h6;
    localparam logic [3:0] OP_BNE   = 4'h7;
    localparam logic [3:0] OP_J     = 4'h8;
    localparam logic [3:0] OP_JAL   = 4'h9;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // ALUOp codes understood by ALU_Control
    localparam logic [2:0] ALUOP_RTYPE = 3'd0;
    localparam logic [2:0] ALUOP_SHI   = 3'd1;
    localparam logic [2:0] ALUOP_ADD   = 3'd2;
    localparam logic [2:0] ALUOP_SUB   = 3'd3;
    localparam logic [2:0] ALUOP_SLT   = 3'd7;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_EXEC_R    = 4'd2,
        S_EXEC_SHI  = 4'd3,
        S_EXEC_ADDI = 4'd4,
        S_EXEC_SLTI = 4'd5,
        S_ALU_WB    = 4'd6,
        S_MEM_ADDR  = 4'd7,
        S_MEM_READ  = 4'd8,
        S_MEM_WB    = 4'd9,
        S_MEM_WRITE = 4'd10,
        S_BRANCH    = 4'd11,
        S_JUMP      = 4'd12,
        S_JAL       = 4'd13,
        S_UNUSED    = 4'd14,
        S_HALT      = 4'd15
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   rtype_q;    // current instruction is R-type (selects rd on writeback)
    logic   rtype_d;
    logic   illegal_q;  // unknown opcode seen in the previous DECODE
    logic   illegal_d;

    // State and instruction-tracking registers; reset aborts any instruction
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_FETCH;
            rtype_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rtype_q   <= rtype_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic, rtype capture and illegal-opcode detection
    always_comb begin
        state_d   = state_q;
        rtype_d   = rtype_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                rtype_d = (opcode == OP_RTYPE);
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_SHI:        state_d = S_EXEC_SHI;
                    OP_ADDI:       state_d = S_EXEC_ADDI;
                    OP_SLTI:       state_d = S_EXEC_SLTI;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_JAL:        state_d = S_JAL;
                    OP_HALT:       state_d = S_HALT;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_SHI, S_EXEC_ADDI, S_EXEC_SLTI: begin
                state_d = S_ALU_WB;
            end
            S_ALU_WB: begin
                state_d = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEM_WRITE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                state_d = S_FETCH;
            end
            S_MEM_WRITE: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_BRANCH, S_JUMP, S_JAL: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Datapath control decode from the registered state; everything is forced
    // low while reset_n is asserted so no strobe can leak out during reset
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        pc_source     = 2'd0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 3'd0;
        illegal_op    = 1'b0;
        halted        = 1'b0;
        if (reset_n) begin
            alu_op     = ALUOP_ADD;
            illegal_op = illegal_q;
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = PC_INC_SEL;
                    // PC and IR only load on the cycle the read completes
                    pc_write  = mem_ready;
                    ir_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b = BR_OFF_SEL;
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_RTYPE;
                end
                S_EXEC_SHI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = IMM_SEL;
                    alu_op    = ALUOP_SHI;
                end
                S_EXEC_ADDI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = IMM_SEL;
                end
                S_EXEC_SLTI: begin
                    alu_src_a = 1'b1;
                    alu_src_b = IMM_SEL;
                    alu_op    = ALUOP_SLT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = rtype_q ? 2'd1 : 2'd0;
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = IMM_SEL;
                end
                S_MEM_READ: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 2'd1;
                end
                S_MEM_WRITE: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'd1;
                    branch_ne     = (opcode == OP_BNE);
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'd2;
                end
                S_JAL: begin
                    // PC already holds PC+2, so it is the link value for r7
                    reg_write  = 1'b1;
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_source  = 2'd2;
                end
                S_HALT: begin
                    halted = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Debug view of the current state
    always_comb begin
        state = state_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Brief    : Scoreboard bench for multicycle_control. The stimulus process
//            queues the expected control word for every cycle it drives; a
//            monitor pops and compares on each falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       branch_ne;
        logic [1:0] pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic       illegal_op;
        logic       halted;
        logic [3:0] state;
    } outs_t;

    typedef struct {
        string name;
        outs_t o;
    } exp_t;

    logic       CLK;
    logic       reset_n;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, reg_write, alu_src_a, illegal_op, halted;
    logic [1:0] pc_source, reg_dst, mem_to_reg, alu_src_b;
    logic [2:0] alu_op;
    logic [3:0] state;
    outs_t      act;

    int checks   = 0;
    int failures = 0;
    exp_t exp_q[$];

    multicycle_control dut (
        .CLK           (CLK),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .pc_source     (pc_source),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .reg_write     (reg_write),
        .reg_dst       (reg_dst),
        .mem_to_reg    (mem_to_reg),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .halted        (halted),
        .state         (state)
    );

    assign act = {pc_write, pc_write_cond, branch_ne, pc_source, iord, mem_read,
                  mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a,
                  alu_src_b, alu_op, illegal_op, halted, state};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected control word for one cycle, written from the state table.
    // mr = mem_ready this cycle, rt = R-type writeback, ne = bne, ill = illegal flag
    function automatic outs_t exp_out(input int st, input bit mr, input bit rt,
                                      input bit ne, input bit ill);
        outs_t o;
        o        = '0;
        o.alu_op = 3'd2;
        o.state  = 4'(st);
        case (st)
            0:  begin o.mem_read = 1'b1; o.alu_src_b = 2'd1; o.pc_write = mr;
                      o.ir_write = mr; o.illegal_op = ill; end
            1:  begin o.alu_src_b = 2'd3; end
            2:  begin o.alu_src_a = 1'b1; o.alu_op = 3'd0; end
            3:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 3'd1; end
            4:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            5:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.alu_op = 3'd7; end
            6:  begin o.reg_write = 1'b1; o.reg_dst = rt ? 2'd1 : 2'd0; end
            7:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; end
            8:  begin o.mem_read = 1'b1; o.iord = 1'b1; end
            9:  begin o.reg_write = 1'b1; o.mem_to_reg = 2'd1; end
            10: begin o.mem_write = 1'b1; o.iord = 1'b1; end
            11: begin o.alu_src_a = 1'b1; o.alu_op = 3'd3; o.pc_write_cond = 1'b1;
                      o.pc_source = 2'd1; o.branch_ne = ne; end
            12: begin o.pc_write = 1'b1; o.pc_source = 2'd2; end
            13: begin o.reg_write = 1'b1; o.reg_dst = 2'd2; o.mem_to_reg = 2'd2;
                      o.pc_write = 1'b1; o.pc_source = 2'd2; end
            15: begin o.halted = 1'b1; end
            default: begin end
        endcase
        return o;
    endfunction

    task automatic compare(input string nm, input outs_t a, input outs_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)",
                     nm, a, a.state, e, e.state);
        end
    endtask

    // One driven cycle: apply inputs, queue the expectation, advance
    task automatic cyc(input string nm, input logic [3:0] op, input bit mr, input outs_t e);
        exp_t x;
        opcode    = op;
        mem_ready = mr;
        x.name    = nm;
        x.o       = e;
        exp_q.push_back(x);
        @(posedge CLK);
        #1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            compare(x.name, act, x.o);
        end
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        opcode    = 4'h0;
        mem_ready = 1'b0;
        @(posedge CLK);
        #1;
        cyc("reset0", 4'h0, 1'b1, outs_t'(0));
        cyc("reset1", 4'h0, 1'b1, outs_t'(0));
        reset_n = 1'b1;

        // R-type: 0,1,2,6
        cyc("r_fetch",  4'h0, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("r_decode", 4'h0, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("r_exec",   4'h0, 1'b1, exp_out(2, 1, 0, 0, 0));
        cyc("r_wb",     4'h0, 1'b1, exp_out(6, 1, 1, 0, 0));

        // addi with two fetch wait states, writes rt
        cyc("addi_fwait0", 4'h2, 1'b0, exp_out(0, 0, 0, 0, 0));
        cyc("addi_fwait1", 4'h2, 1'b0, exp_out(0, 0, 0, 0, 0));
        cyc("addi_fetch",  4'h2, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("addi_decode", 4'h2, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("addi_exec",   4'h2, 1'b1, exp_out(4, 1, 0, 0, 0));
        cyc("addi_wb",     4'h2, 1'b1, exp_out(6, 1, 0, 0, 0));

        // shift-imm and slti execute cycles
        cyc("shi_fetch",  4'h1, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("shi_decode", 4'h1, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("shi_exec",   4'h1, 1'b1, exp_out(3, 1, 0, 0, 0));
        cyc("shi_wb",     4'h1, 1'b1, exp_out(6, 1, 0, 0, 0));
        cyc("slti_fetch",  4'h3, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("slti_decode", 4'h3, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("slti_exec",   4'h3, 1'b1, exp_out(5, 1, 0, 0, 0));
        cyc("slti_wb",     4'h3, 1'b1, exp_out(6, 1, 0, 0, 0));

        // lw with three wait states in MEM_READ: 8 cycles total
        cyc("lw_fetch",  4'h4, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("lw_decode", 4'h4, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("lw_addr",   4'h4, 1'b1, exp_out(7, 1, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("lw_wait%0d", i), 4'h4, 1'b0, exp_out(8, 0, 0, 0, 0));
        end
        cyc("lw_read",   4'h4, 1'b1, exp_out(8, 1, 0, 0, 0));
        cyc("lw_wb",     4'h4, 1'b1, exp_out(9, 1, 0, 0, 0));

        // sw with one stall cycle
        cyc("sw_fetch",  4'h5, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("sw_decode", 4'h5, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("sw_addr",   4'h5, 1'b1, exp_out(7, 1, 0, 0, 0));
        cyc("sw_wait",   4'h5, 1'b0, exp_out(10, 0, 0, 0, 0));
        cyc("sw_write",  4'h5, 1'b1, exp_out(10, 1, 0, 0, 0));

        // bne / beq / j / jal
        cyc("bne_fetch",  4'h7, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("bne_decode", 4'h7, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("bne_branch", 4'h7, 1'b1, exp_out(11, 1, 0, 1, 0));
        cyc("beq_fetch",  4'h6, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("beq_decode", 4'h6, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("beq_branch", 4'h6, 1'b1, exp_out(11, 1, 0, 0, 0));
        cyc("j_fetch",    4'h8, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("j_decode",   4'h8, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("j_jump",     4'h8, 1'b1, exp_out(12, 1, 0, 0, 0));
        cyc("jal_fetch",  4'h9, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("jal_decode", 4'h9, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("jal_jal",    4'h9, 1'b1, exp_out(13, 1, 0, 0, 0));

        // Illegal opcode: flag for exactly one FETCH cycle
        cyc("ill_fetch",  4'hB, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("ill_decode", 4'hB, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("ill_flag",   4'hB, 1'b0, exp_out(0, 0, 0, 0, 1));
        cyc("ill_clear",  4'hB, 1'b0, exp_out(0, 0, 0, 0, 0));

        // Async reset during a MEM_WRITE stall
        cyc("swr_fetch",  4'h5, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("swr_decode", 4'h5, 1'b1, exp_out(1, 1, 0, 0, 0));
        cyc("swr_addr",   4'h5, 1'b1, exp_out(7, 1, 0, 0, 0));
        cyc("swr_wait",   4'h5, 1'b0, exp_out(10, 0, 0, 0, 0));
        #1;
        compare("swr_pre_reset", act, exp_out(10, 0, 0, 0, 0));
        reset_n = 1'b0;
        #1;
        compare("swr_async_reset", act, outs_t'(0));
        @(posedge CLK);
        #1;
        reset_n = 1'b1;

        // Halt: held for 20 cycles regardless of inputs
        cyc("halt_fetch",  4'hF, 1'b1, exp_out(0, 1, 0, 0, 0));
        cyc("halt_decode", 4'hF, 1'b1, exp_out(1, 1, 0, 0, 0));
        for (int i = 0; i < 20; i++) begin
            cyc($sformatf("halt_hold%0d", i), 4'(i), 1'(i), exp_out(15, 1'(i), 0, 0, 0));
        end

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
